// File: rtl/cv32e40x_aes_share_issuer.sv
// rtl/cv32e40x_aes_share_issuer.sv - initiator side of the masked saes32 functional-unit interface
//
// Splits the request's rs2 bytes [7:0]/[15:8] into two Boolean shares with fresh masks.
// Presents the share-packed operands plus DOM randomness to the protected AES unit.
// Holds them for SBOX_LATENCY cycles, captures the result and returns it over a
// valid/ready response handshake.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   req_valid_i/ready_o request handshake from EX
//   req_rs1_i           round key / accumulator word
//   req_rs2_i           unmasked state word (bytes [7:0], [15:8] used)
//   req_bs_i, req_op_i  byte select, one-hot {encsm, encs, decsm, decs}
//   rnd_i               [15:0] masks m1:m0, [51:16] DOM gadget randomness
//   kill_i              pipeline flush
//   fu_*_o              operands to the AES unit, fu_rd_i its result
//   res_valid_o/ready_i response handshake, res_rd_o result word

module cv32e40x_aes_share_issuer #(
  parameter int unsigned SBOX_LATENCY = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_rs1_i,
  input  logic [31:0] req_rs2_i,
  input  logic [1:0]  req_bs_i,
  input  logic [3:0]  req_op_i,
  input  logic [51:0] rnd_i,
  input  logic        kill_i,
  output logic        fu_valid_o,
  output logic [31:0] fu_rs1_o,
  output logic [31:0] fu_rs2_o,
  output logic [35:0] fu_randombits_o,
  output logic [1:0]  fu_bs_o,
  output logic [3:0]  fu_op_o,
  input  logic [31:0] fu_rd_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [31:0] res_rd_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SBOX_LATENCY - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        accept;
  logic [31:0] rs2_shared;
  logic        unused_rs2_hi;

  // Gated by reset_n so nothing can be accepted while the FSM is held in reset.
  assign req_ready_o = reset_n && !kill_i &&
                       ((state == IDLE) || ((state == RESP) && res_ready_i));
  assign accept      = req_valid_i && req_ready_o;

  // Share layout: {m1, m0, byte1^m1, byte0^m0}. The unmasked bytes only exist
  // combinationally here; only the masked form is ever registered.
  assign rs2_shared  = {rnd_i[15:8], rnd_i[7:0],
                        req_rs2_i[15:8] ^ rnd_i[15:8],
                        req_rs2_i[7:0]  ^ rnd_i[7:0]};

  assign unused_rs2_hi = ^req_rs2_i[31:16];

  always_ff @(posedge clk) begin
    if (!reset_n || kill_i) begin
      // A flush behaves like reset: in-flight work is dropped with no response.
      state           <= IDLE;
      cnt             <= '0;
      fu_valid_o      <= 1'b0;
      fu_rs1_o        <= '0;
      fu_rs2_o        <= '0;
      fu_randombits_o <= '0;
      fu_bs_o         <= '0;
      fu_op_o         <= '0;
      res_valid_o     <= 1'b0;
      res_rd_o        <= '0;
    end else begin
      case (state)
        IDLE: ;
        ISSUE: begin
          if (cnt == 4'd0) begin
            res_rd_o        <= fu_rd_i;
            res_valid_o     <= 1'b1;
            // Shares are wiped from the unit inputs as soon as they are no longer needed.
            fu_valid_o      <= 1'b0;
            fu_rs1_o        <= '0;
            fu_rs2_o        <= '0;
            fu_randombits_o <= '0;
            fu_bs_o         <= '0;
            fu_op_o         <= '0;
            state           <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            res_rd_o    <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // accept is only possible in IDLE or on the RESP handshake, so this
      // override gives the back-to-back RESP -> ISSUE path without a bubble.
      if (accept) begin
        fu_valid_o      <= 1'b1;
        fu_rs1_o        <= req_rs1_i;
        fu_rs2_o        <= rs2_shared;
        fu_randombits_o <= rnd_i[51:16];
        fu_bs_o         <= req_bs_i;
        fu_op_o         <= req_op_i;
        cnt             <= CNT_INIT;
        state           <= ISSUE;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40x_aes_share_issuer.sv
// tb/tb_cv32e40x_aes_share_issuer.sv - self-checking bench for cv32e40x_aes_share_issuer
module tb_cv32e40x_aes_share_issuer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, req_valid, kill, res_ready;
  logic [31:0] req_rs1, req_rs2;
  logic [1:0]  req_bs;
  logic [3:0]  req_op;
  logic [51:0] rnd;

  logic        req_ready_a, fu_valid_a, res_valid_a;
  logic [31:0] fu_rs1_a, fu_rs2_a, fu_rd_a, res_rd_a;
  logic [35:0] fu_rb_a;
  logic [1:0]  fu_bs_a;
  logic [3:0]  fu_op_a;

  logic        req_ready_b, fu_valid_b, res_valid_b;
  logic [31:0] fu_rs1_b, fu_rs2_b, fu_rd_b, res_rd_b;
  logic [35:0] fu_rb_b;
  logic [1:0]  fu_bs_b;
  logic [3:0]  fu_op_b;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  localparam logic [3:0] OP_ENCSM = 4'b1000;
  localparam logic [3:0] OP_ENCS  = 4'b0100;

  cv32e40x_aes_share_issuer #(.SBOX_LATENCY(5)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_a),
    .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_bs_i(req_bs), .req_op_i(req_op),
    .rnd_i(rnd), .kill_i(kill),
    .fu_valid_o(fu_valid_a), .fu_rs1_o(fu_rs1_a), .fu_rs2_o(fu_rs2_a),
    .fu_randombits_o(fu_rb_a), .fu_bs_o(fu_bs_a), .fu_op_o(fu_op_a), .fu_rd_i(fu_rd_a),
    .res_valid_o(res_valid_a), .res_ready_i(res_ready), .res_rd_o(res_rd_a)
  );

  cv32e40x_aes_share_issuer #(.SBOX_LATENCY(1)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_b),
    .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_bs_i(req_bs), .req_op_i(req_op),
    .rnd_i(rnd), .kill_i(kill),
    .fu_valid_o(fu_valid_b), .fu_rs1_o(fu_rs1_b), .fu_rs2_o(fu_rs2_b),
    .fu_randombits_o(fu_rb_b), .fu_bs_o(fu_bs_b), .fu_op_o(fu_op_b), .fu_rd_i(fu_rd_b),
    .res_valid_o(res_valid_b), .res_ready_i(res_ready), .res_rd_o(res_rd_b)
  );

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] aes_f(input logic [31:0] rs1, input logic [7:0] x,
                                        input logic [1:0] bs, input logic [3:0] op);
    logic [7:0]  s;
    logic [31:0] mix;
    int          sh;
    s  = sbox(x);
    sh = 8 * int'(bs);
    if (op[3]) mix = {gmul(s, 8'h03), s, s, gmul(s, 8'h02)};
    else       mix = {24'h0, s};
    return rs1 ^ ((mix << sh) | (mix >> (32 - sh)));
  endfunction

  // Behavioural AES units: recombine the shares and present the result only in
  // the cycle the real unit would, garbage otherwise.
  int vcnt_a = 0;
  int vcnt_b = 0;
  always @(posedge clk) begin
    vcnt_a <= fu_valid_a ? vcnt_a + 1 : 0;
    vcnt_b <= fu_valid_b ? vcnt_b + 1 : 0;
  end
  always_comb begin
    fu_rd_a = 32'hBAD0_BAD0;
    if (fu_valid_a && vcnt_a == 4)
      fu_rd_a = aes_f(fu_rs1_a, fu_rs2_a[7:0] ^ fu_rs2_a[23:16], fu_bs_a, fu_op_a);
  end
  always_comb begin
    fu_rd_b = 32'hBAD1_BAD1;
    if (fu_valid_b && vcnt_b == 0)
      fu_rd_b = aes_f(fu_rs1_b, fu_rs2_b[7:0] ^ fu_rs2_b[23:16], fu_bs_b, fu_op_b);
  end

  typedef struct packed {
    logic [3:0]  op;
    logic [1:0]  bs;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [15:0] m;
    logic [31:0] exp;
  } row_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] rs1, input logic [31:0] rs2, input logic [1:0] bs,
                           input logic [3:0] op, input logic [51:0] r, input bit use_b);
    int w;
    req_rs1 = rs1; req_rs2 = rs2; req_bs = bs; req_op = op; rnd = r;
    req_valid = 1'b1;
    w = 0;
    #1;
    while (!(use_b ? req_ready_b : req_ready_a) && w < 50) begin
      tick();
      #1;
      w++;
    end
    n_tests++;
    if (w >= 50) begin
      n_fail++;
      $display("FAIL accept_timeout: ready still 0 after %0d cycles, required 1", w);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic rand_req(output logic [31:0] e);
    req_rs1 = $urandom;
    req_rs2 = $urandom;
    req_bs  = 2'($urandom_range(0, 3));
    req_op  = ($urandom_range(0, 1) == 1) ? OP_ENCSM : OP_ENCS;
    rnd     = {20'($urandom), 32'($urandom)};
    e = aes_f(req_rs1, req_rs2[7:0], req_bs, req_op);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b1; kill = 1'b0; res_ready = 1'b0;
    req_rs1 = 32'hFFFF_FFFF; req_rs2 = 32'hFFFF_FFFF; req_bs = 2'd3; req_op = OP_ENCS; rnd = '1;
    repeat (3) tick();
    n_tests++;
    if (req_ready_a !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_a: got %b required 0", req_ready_a);
    end
    n_tests++;
    if (req_ready_b !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_b: got %b required 0", req_ready_b);
    end
    req_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    n_tests++;
    if ({fu_valid_a, fu_rs1_a, fu_rs2_a, fu_rb_a, fu_bs_a, fu_op_a, res_valid_a, res_rd_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0",
               {fu_valid_a, fu_rs1_a, fu_rs2_a, fu_rb_a, fu_bs_a, fu_op_a, res_valid_a, res_rd_a});
    end
    n_tests++;
    if (req_ready_a !== 1'b1) begin
      n_fail++; $display("FAIL reset_idle_ready: got %b required 1", req_ready_a);
    end
    exp_q.delete();
  endtask

  task automatic test_single();
    row_t rows[6];
    rows[0] = '{OP_ENCS,  2'd0, 32'h0,         32'h0,  16'h00A5, 32'h0000_0063};
    rows[1] = '{OP_ENCS,  2'd0, 32'h0,         32'h0,  16'h0000, 32'h0000_0063};
    rows[2] = '{OP_ENCS,  2'd0, 32'h0,         32'h0,  16'hFFFF, 32'h0000_0063};
    rows[3] = '{OP_ENCSM, 2'd0, 32'h0,         32'h0,  16'h3C5A, 32'hA563_63C6};
    rows[4] = '{OP_ENCSM, 2'd1, 32'h0,         32'h0,  16'h7E81, 32'h6363_C6A5};
    rows[5] = '{OP_ENCS,  2'd0, 32'h1111_1111, 32'h53, 16'h1234, 32'h1111_11FC};
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [51:0]  r;
      logic [105:0] snap;
      logic [31:0]  e;
      int           n;
      bit           stable;
      r = {4'($urandom), 32'($urandom), rows[i].m};
      drive_req(rows[i].rs1, rows[i].rs2, rows[i].bs, rows[i].op, r, 1'b0);
      exp_q.push_back(rows[i].exp);
      n_tests++;
      if (fu_rs2_a !== {r[15:8], r[7:0], rows[i].rs2[15:8] ^ r[15:8], rows[i].rs2[7:0] ^ r[7:0]}) begin
        n_fail++; $display("FAIL share_pack[%0d]: got %h", i, fu_rs2_a);
      end
      n_tests++;
      if ({fu_rs1_a, fu_rb_a, fu_bs_a, fu_op_a} !== {rows[i].rs1, r[51:16], rows[i].bs, rows[i].op}) begin
        n_fail++;
        $display("FAIL operand_fwd[%0d]: got %h required %h", i, {fu_rs1_a, fu_rb_a, fu_bs_a, fu_op_a},
                 {rows[i].rs1, r[51:16], rows[i].bs, rows[i].op});
      end
      snap = {fu_rs1_a, fu_rs2_a, fu_rb_a, fu_bs_a, fu_op_a};
      n = 0;
      stable = 1'b1;
      while (fu_valid_a && n < 20) begin
        if ({fu_rs1_a, fu_rs2_a, fu_rb_a, fu_bs_a, fu_op_a} !== snap) stable = 1'b0;
        n++;
        tick();
      end
      n_tests++;
      if (n != 5) begin
        n_fail++; $display("FAIL fu_valid_cycles[%0d]: got %0d required 5", i, n);
      end
      n_tests++;
      if (!stable) begin
        n_fail++; $display("FAIL operand_hold[%0d]: got unstable required stable", i);
      end
      n_tests++;
      if (res_valid_a !== 1'b1) begin
        n_fail++; $display("FAIL res_valid_timing[%0d]: got %b required 1", i, res_valid_a);
      end
      n_tests++;
      if ({fu_rs1_a, fu_rs2_a, fu_rb_a, fu_bs_a, fu_op_a} !== '0) begin
        n_fail++; $display("FAIL fu_cleared[%0d]: got %h required 0", i, {fu_rs1_a, fu_rs2_a, fu_rb_a, fu_bs_a, fu_op_a});
      end
      e = exp_q.pop_front();
      n_tests++;
      if (res_rd_a !== e) begin
        n_fail++; $display("FAIL res_rd[%0d]: got %h required %h", i, res_rd_a, e);
      end
      tick();
      n_tests++;
      if ({res_valid_a, res_rd_a} !== '0) begin
        n_fail++; $display("FAIL res_clear[%0d]: got %h required 0", i, {res_valid_a, res_rd_a});
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] e1, e2, e;
    logic [51:0] r2;
    int          w;
    bit          hold_ok, rdy_ok;
    res_ready = 1'b0;
    drive_req(32'h1234_5678, 32'h0000_00C3, 2'd0, OP_ENCS, {20'($urandom), 32'($urandom)}, 1'b0);
    e1 = aes_f(32'h1234_5678, 8'hC3, 2'd0, OP_ENCS);
    exp_q.push_back(e1);
    w = 0;
    while (!res_valid_a && w < 20) begin tick(); w++; end
    n_tests++;
    if (w >= 20) begin
      n_fail++; $display("FAIL stall_resp_timeout: res_valid 0 after %0d cycles, required 1", w);
    end
    r2 = {20'($urandom), 32'($urandom)};
    req_rs1 = 32'h0; req_rs2 = 32'h53; req_bs = 2'd3; req_op = OP_ENCSM; rnd = r2;
    req_valid = 1'b1;
    e2 = aes_f(32'h0, 8'h53, 2'd3, OP_ENCSM);
    e = exp_q.pop_front();
    hold_ok = 1'b1;
    rdy_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (res_valid_a !== 1'b1 || res_rd_a !== e) hold_ok = 1'b0;
      if (req_ready_a !== 1'b0) rdy_ok = 1'b0;
      tick();
    end
    n_tests++;
    if (!hold_ok) begin
      n_fail++; $display("FAIL stall_hold: got valid=%b rd=%h required 1 %h", res_valid_a, res_rd_a, e);
    end
    n_tests++;
    if (!rdy_ok) begin
      n_fail++; $display("FAIL stall_ready: got ready=1 during stall, required 0");
    end
    res_ready = 1'b1;
    #1;
    n_tests++;
    if (req_ready_a !== 1'b1) begin
      n_fail++; $display("FAIL handshake_ready: got %b required 1", req_ready_a);
    end
    tick();
    req_valid = 1'b0;
    exp_q.push_back(e2);
    n_tests++;
    if ({fu_valid_a, res_valid_a} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_issue: got fu_valid,res_valid=%b required 10", {fu_valid_a, res_valid_a});
    end
    n_tests++;
    if (fu_rs2_a !== {r2[15:8], r2[7:0], r2[15:8], 8'h53 ^ r2[7:0]}) begin
      n_fail++; $display("FAIL b2b_pack: got %h required %h", fu_rs2_a, {r2[15:8], r2[7:0], r2[15:8], 8'h53 ^ r2[7:0]});
    end
    w = 0;
    while (!res_valid_a && w < 20) begin tick(); w++; end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
    n_tests++;
    if (res_rd_a !== e) begin
      n_fail++; $display("FAIL b2b_result: got %h required %h", res_rd_a, e);
    end
    tick();
  endtask

  task automatic test_kill();
    bit seen;
    res_ready = 1'b1;
    drive_req(32'hCAFE_F00D, 32'h77, 2'd1, OP_ENCSM, {20'($urandom), 32'($urandom)}, 1'b0);
    tick();
    tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    #1;
    n_tests++;
    if ({fu_valid_a, fu_rs1_a, fu_rs2_a, fu_rb_a, fu_bs_a, fu_op_a, res_valid_a, res_rd_a} !== '0) begin
      n_fail++; $display("FAIL kill_clear: got %h required 0", {fu_valid_a, fu_rs1_a, fu_rs2_a, fu_rb_a, fu_bs_a, fu_op_a});
    end
    n_tests++;
    if (req_ready_a !== 1'b1) begin
      n_fail++; $display("FAIL kill_idle: got ready=%b required 1", req_ready_a);
    end
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (res_valid_a) seen = 1'b1;
      tick();
    end
    n_tests++;
    if (seen) begin
      n_fail++; $display("FAIL kill_no_resp: got res_valid=1 required 0");
    end
    req_rs1 = 32'h1; req_rs2 = 32'h2; req_bs = 2'd0; req_op = OP_ENCS;
    req_valid = 1'b1;
    kill = 1'b1;
    #1;
    n_tests++;
    if (req_ready_a !== 1'b0) begin
      n_fail++; $display("FAIL kill_blocks_ready: got %b required 0", req_ready_a);
    end
    tick();
    req_valid = 1'b0;
    kill = 1'b0;
    n_tests++;
    if (fu_valid_a !== 1'b0) begin
      n_fail++; $display("FAIL kill_blocks_accept: got fu_valid=%b required 0", fu_valid_a);
    end
  endtask

  task automatic test_back_to_back(input bit use_b, input int lat);
    logic [31:0] nxt, e, rd;
    int          sent, got, cyc, last;
    bit          gap_ok, rv, acc;
    sent = 0; got = 0; cyc = 0; last = -1; gap_ok = 1'b1;
    res_ready = 1'b1;
    rand_req(nxt);
    req_valid = 1'b1;
    while (got < 6 && cyc < 400) begin
      #1;
      rv  = use_b ? res_valid_b : res_valid_a;
      rd  = use_b ? res_rd_b : res_rd_a;
      acc = req_valid && (use_b ? req_ready_b : req_ready_a);
      if (rv) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        n_tests++;
        if (rd !== e) begin
          n_fail++; $display("FAIL b2b_rd[lat%0d,%0d]: got %h required %h", lat, got, rd, e);
        end
        if (last >= 0 && cyc - last != lat + 1) gap_ok = 1'b0;
        last = cyc;
        got++;
      end
      tick();
      cyc++;
      if (acc) begin
        exp_q.push_back(nxt);
        sent++;
        if (sent < 6) rand_req(nxt);
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    n_tests++;
    if (got != 6) begin
      n_fail++; $display("FAIL b2b_count[lat%0d]: got %0d results required 6", lat, got);
    end
    n_tests++;
    if (!gap_ok) begin
      n_fail++; $display("FAIL b2b_rate[lat%0d]: result spacing not %0d cycles", lat, lat + 1);
    end
  endtask

  task automatic test_lat1();
    int n;
    reset_n = 1'b0; req_valid = 1'b0; kill = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    exp_q.delete();
    res_ready = 1'b1;
    drive_req(32'h0, 32'h0, 2'd0, OP_ENCS, {36'h0, 16'h00A5}, 1'b1);
    n_tests++;
    if ({fu_valid_b, fu_rs2_b} !== {1'b1, 32'h00A5_00A5}) begin
      n_fail++; $display("FAIL lat1_issue: got %h required 100a500a5", {fu_valid_b, fu_rs2_b});
    end
    n = 0;
    while (fu_valid_b && n < 10) begin n++; tick(); end
    n_tests++;
    if (n != 1) begin
      n_fail++; $display("FAIL lat1_valid_cycles: got %0d required 1", n);
    end
    n_tests++;
    if ({res_valid_b, res_rd_b} !== {1'b1, 32'h0000_0063}) begin
      n_fail++; $display("FAIL lat1_result: got %h required 100000063", {res_valid_b, res_rd_b});
    end
    tick();
    test_back_to_back(1'b1, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_kill();
    test_back_to_back(1'b0, 5);
    test_lat1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
